// File: rtl/dual_issue_sched.sv
// Issue scheduler for the head decoded pair: selects none/slot0/slot1/both each cycle,
// tracking load-use hazards per register and serialising privileged/trap instructions.
module dual_issue_sched #(
    parameter int LOAD_LAT = 2,
    parameter int NREG     = 32
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       flush,
    input  logic       pair_valid,
    input  logic       v0,
    input  logic       v1,
    input  logic       alu0,
    input  logic       alu1,
    input  logic       priv0,
    input  logic       priv1,
    input  logic       trap0,
    input  logic       trap1,
    input  logic       we0,
    input  logic       we1,
    input  logic       ld0,
    input  logic       ld1,
    input  logic [4:0] rd0,
    input  logic [4:0] rd1,
    input  logic [4:0] rj0,
    input  logic [4:0] rk0,
    input  logic [4:0] rj1,
    input  logic [4:0] rk1,
    input  logic       exe_allowin,
    input  logic       inflight_empty,
    input  logic       cmt_priv,
    output logic       issue0,
    output logic       issue1,
    output logic       pair_pop,
    output logic [1:0] sched_state
);

    // Handshake: a slot transfers to execute only in a cycle where it is issued and
    // exe_allowin is high; the pair transfers upstream in a cycle where pair_valid
    // and pair_pop are both high. Neither side may retract a request mid-cycle.

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_DRAIN  = 2'b01,
        S_SERIAL = 2'b10
    } state_t;

    localparam logic [1:0] LAT = 2'(LOAD_LAT);

    state_t     state;
    state_t     state_nxt;
    logic       half;
    logic [1:0] cnt [NREG];

    logic [NREG-1:0] busy_v;
    logic [NREG-1:0] load_set;

    logic haz0;
    logic haz1;
    logic solo1;
    logic head_v;
    logic head_ser;
    logic head_haz;
    logic head_ok;
    logic head_issue;
    logic drain_req;
    logic raw01;
    logic dual_ok;
    logic iss0;
    logic iss1;
    logic pop;

    // Lane0 accepts every class, so the slot0 ALU flag carries no scheduling weight.
    logic unused_alu0;
    assign unused_alu0 = alu0;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_v[r] = (r != 0) && (cnt[r] != 2'd0);
        end
    end

    assign haz0 = busy_v[rj0] | busy_v[rk0];
    assign haz1 = busy_v[rj1] | busy_v[rk1];

    // Issue decision. The head slot is slot1 once slot0 has gone (half) or is absent.
    always_comb begin
        solo1      = half | ~v0;
        head_v     = solo1 ? v1 : v0;
        head_ser   = solo1 ? (priv1 | trap1) : (priv0 | trap0);
        head_haz   = solo1 ? haz1 : haz0;
        head_ok    = ~areset & ~flush & pair_valid & head_v & exe_allowin
                   & (state == S_RUN) & ~head_haz;
        head_issue = head_ok & (~head_ser | inflight_empty);
        drain_req  = head_ok & head_ser & ~inflight_empty;
        raw01      = we0 & (rd0 != 5'd0) & ((rd0 == rj1) | (rd0 == rk1) | (rd0 == rd1));
        dual_ok    = v1 & alu1 & ~priv1 & ~trap1 & ~priv0 & ~trap0 & ~haz1 & ~raw01;
        iss0       = head_issue & ~solo1;
        iss1       = (head_issue & solo1) | (iss0 & dual_ok);
        pop        = ~areset & ~flush & pair_valid & (solo1 | iss0) & (~v1 | iss1);
    end

    assign issue0      = iss0;
    assign issue1      = iss1;
    assign pair_pop    = pop;
    assign sched_state = state;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (drain_req) begin
                    state_nxt = S_DRAIN;
                end else if (head_issue && head_ser) begin
                    state_nxt = S_SERIAL;
                end
            end
            S_DRAIN: begin
                if (inflight_empty) begin
                    state_nxt = S_RUN;
                end
            end
            S_SERIAL: begin
                if (cmt_priv) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
        if (flush) begin
            state_nxt = S_RUN;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            half <= 1'b0;
        end else if (flush || pop) begin
            half <= 1'b0;
        end else if (iss0 && v1 && !iss1) begin
            half <= 1'b1;
        end
    end

    // A newly issued load reloads its destination counter, overriding the decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            load_set[r] = (r != 0)
                        && ((iss0 & ld0 & we0 & (rd0 == 5'(r)))
                         || (iss1 & ld1 & we1 & (rd1 == 5'(r))));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (flush) begin
                    cnt[r] <= 2'd0;
                end else if (load_set[r]) begin
                    cnt[r] <= LAT;
                end else if (cnt[r] != 2'd0) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
        end
    end

endmodule
